// File: rtl/branch_target_predictor_pkg.sv
// Shared types for the branch target predictor: BTB entry layout,
// direction counter encoding and index/tag geometry helpers.
package cva5_types;

  localparam int BTB_TAG_MAX = 24;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } ctr_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } btb_state_t;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_MAX-1:0] tag;
    logic [30:0]            target;
    ctr_t                   ctr;
    logic                   is_branch;
    logic                   is_return;
    logic                   is_call;
  } btb_entry_t;

  function automatic int btb_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int btb_tag_lsb(input int entries);
    return $clog2(entries) + 2;
  endfunction

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken && c != STRONG_T)
      n = ctr_t'(c + 2'd1);
    else if (!taken && c != STRONG_NT)
      n = ctr_t'(c - 2'd1);
    return n;
  endfunction

endpackage

// File: rtl/branch_target_predictor_ras.sv
// Circular return address stack; a push when full overwrites the
// oldest entry, a pop when empty is ignored.
module return_address_stack
  import cva5_types::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_pc,
  output logic [31:0] top,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   stk [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0]   cnt;
  logic [PW-1:0] top_idx;

  assign top_idx = ptr - 1'b1;
  assign top     = stk[top_idx];
  assign empty   = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && pop && !empty) begin
      // call and return in one slot: replace the top in place
      stk[top_idx] <= push_pc;
    end else if (push) begin
      stk[ptr] <= push_pc;
      ptr      <= ptr + 1'b1;
      if (cnt != (PW+1)'(DEPTH))
        cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// BTB with 2-bit direction counters and one-cycle lookup.
// Define BRANCH_PREDICTOR_RAS_EN to add a return address stack.
module branch_target_predictor
  import cva5_types::*;
#(
  parameter int ENTRIES   = 512,
  parameter int TAG_W     = 9,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_advance,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_target_pc,
  input  logic        br_taken,
  input  logic        br_is_branch,
  input  logic        br_is_return,
  input  logic        br_is_call,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_pc,
  output logic        pred_hit,
  output logic        init_done
);

  localparam int IDX_W   = btb_idx_w(ENTRIES);
  localparam int TAG_LSB = btb_tag_lsb(ENTRIES);

  btb_state_t       state;
  logic [IDX_W-1:0] init_idx;

  btb_entry_t mem [ENTRIES];

  logic [IDX_W-1:0]       fetch_idx;
  logic [IDX_W-1:0]       upd_idx;
  logic [BTB_TAG_MAX-1:0] fetch_tag;
  logic [BTB_TAG_MAX-1:0] upd_tag;

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign upd_idx   = br_pc[IDX_W+1:2];
  assign fetch_tag = BTB_TAG_MAX'(fetch_pc[TAG_LSB +: TAG_W]);
  assign upd_tag   = BTB_TAG_MAX'(br_pc[TAG_LSB +: TAG_W]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      init_idx  <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == IDX_W'(ENTRIES-1)) begin
            state     <= READY;
            init_done <= 1'b1;
          end
        end
        READY: ;
        default: state <= INIT;
      endcase
    end
  end

  btb_entry_t upd_rd;
  btb_entry_t upd_wr;
  logic       upd_match;
  logic       upd_we;

  always_comb begin
    upd_rd           = mem[upd_idx];
    upd_match        = upd_rd.valid && (upd_rd.tag == upd_tag);
    upd_wr           = '0;
    upd_wr.valid     = 1'b1;
    upd_wr.tag       = upd_tag;
    upd_wr.target    = br_target_pc[31:1];
    upd_wr.is_branch = br_is_branch;
    upd_wr.is_return = br_is_return;
    upd_wr.is_call   = br_is_call;
    upd_wr.ctr       = upd_match ? ctr_next(upd_rd.ctr, br_taken) : WEAK_T;
    upd_we           = (state == READY) && br_valid
                       && (upd_match || br_taken);
  end

  // single write port shared between the clear sweep and updates
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[init_idx] <= '0;
    else if (upd_we)
      mem[upd_idx] <= upd_wr;
  end

  btb_entry_t  look_rd;
  btb_entry_t  ent_r;
  logic        pv_r;
  logic        hit_r;
  logic [31:0] pc_r;
  logic [31:0] seq_pc;

  assign look_rd = mem[fetch_idx];

  // lookup is read combinationally and registered, so a same-cycle
  // update to the same index is seen only by the following lookup
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_r  <= 1'b0;
      hit_r <= 1'b0;
      ent_r <= '0;
      pc_r  <= '0;
    end else begin
      pv_r <= fetch_req;
      if (fetch_req) begin
        ent_r <= look_rd;
        pc_r  <= fetch_pc;
        hit_r <= (state == READY) && look_rd.valid
                 && (look_rd.tag == fetch_tag);
      end
    end
  end

  assign seq_pc     = pc_r + 32'd4;
  assign pred_valid = pv_r;
  assign pred_hit   = pv_r & hit_r;
  assign pred_taken = pred_hit
                      & (~ent_r.is_branch
                         | (ent_r.ctr inside {WEAK_T, STRONG_T}));

`ifdef BRANCH_PREDICTOR_RAS_EN
  logic        ras_push;
  logic        ras_pop;
  logic        ras_empty;
  logic [31:0] ras_top;

  assign ras_push = fetch_advance & pred_hit & ent_r.is_call;
  assign ras_pop  = fetch_advance & pred_hit & ent_r.is_return;

  return_address_stack #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk    (clk),
    .rst    (rst),
    .push   (ras_push),
    .pop    (ras_pop),
    .push_pc(seq_pc),
    .top    (ras_top),
    .empty  (ras_empty)
  );

  always_comb begin
    pred_pc = '0;
    if (pv_r) begin
      if (!pred_taken)
        pred_pc = seq_pc;
      else if (ent_r.is_return && !ras_empty)
        pred_pc = ras_top;
      else
        pred_pc = {ent_r.target, 1'b0};
    end
  end

  logic unused_bits;
  assign unused_bits = ^{fetch_pc, br_pc, br_target_pc[0],
                         upd_rd, ent_r};
`else
  always_comb begin
    pred_pc = '0;
    if (pv_r) begin
      if (!pred_taken)
        pred_pc = seq_pc;
      else
        pred_pc = {ent_r.target, 1'b0};
    end
  end

  logic unused_bits;
  assign unused_bits = ^{fetch_pc, br_pc, br_target_pc[0],
                         upd_rd, ent_r, fetch_advance,
                         32'(RAS_DEPTH)};
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor (ENTRIES=512).
// Return-stack checks follow BRANCH_PREDICTOR_RAS_EN.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_advance;
  logic        br_valid;
  logic [31:0] br_pc;
  logic [31:0] br_target_pc;
  logic        br_taken;
  logic        br_is_branch;
  logic        br_is_return;
  logic        br_is_call;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        pred_hit;
  logic        init_done;

  int total = 0;
  int bad   = 0;
  logic early;

  always #5 clk = ~clk;

  branch_target_predictor #(
    .ENTRIES  (512),
    .TAG_W    (9),
    .RAS_DEPTH(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_req    (fetch_req),
    .fetch_pc     (fetch_pc),
    .fetch_advance(fetch_advance),
    .br_valid     (br_valid),
    .br_pc        (br_pc),
    .br_target_pc (br_target_pc),
    .br_taken     (br_taken),
    .br_is_branch (br_is_branch),
    .br_is_return (br_is_return),
    .br_is_call   (br_is_call),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_pc      (pred_pc),
    .pred_hit     (pred_hit),
    .init_done    (init_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                     input logic tk, input logic isb,
                     input logic isr, input logic isc);
    br_valid     = 1'b1;
    br_pc        = pc;
    br_target_pc = tgt;
    br_taken     = tk;
    br_is_branch = isb;
    br_is_return = isr;
    br_is_call   = isc;
    @(negedge clk);
    br_valid = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  task automatic adv();
    fetch_advance = 1'b1;
    @(negedge clk);
    fetch_advance = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fetch_req = 1'b1;
    fetch_pc = 32'h100;
    fetch_advance = 1'b0;
    br_valid = 1'b0;
    br_pc = '0;
    br_target_pc = '0;
    br_taken = 1'b0;
    br_is_branch = 1'b0;
    br_is_return = 1'b0;
    br_is_call = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pred_valid", 32'(pred_valid), 32'd0);
    chk("rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("rst_pred_hit", 32'(pred_hit), 32'd0);
    chk("rst_pred_pc", pred_pc, 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);

    rst = 1'b0;
    early = 1'b0;
    for (int i = 1; i <= 511; i++) begin
      @(negedge clk);
      if (init_done) early = 1'b1;
      if (i == 100) begin
        chk("init_pred_valid", 32'(pred_valid), 32'd1);
        chk("init_pred_taken", 32'(pred_taken), 32'd0);
      end
    end
    chk("init_early", 32'(early), 32'd0);
    @(negedge clk);
    chk("init_done_512", 32'(init_done), 32'd1);
    fetch_req = 1'b0;
    @(negedge clk);
    chk("no_req_valid", 32'(pred_valid), 32'd0);

    upd(32'h100, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0);
    look(32'h100);
    chk("alloc_hit", 32'(pred_hit), 32'd1);
    chk("alloc_taken", 32'(pred_taken), 32'd1);
    chk("alloc_pc", pred_pc, 32'h200);

    upd(32'h100, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0);
    upd(32'h100, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0);
    look(32'h100);
    chk("nt2_hit", 32'(pred_hit), 32'd1);
    chk("nt2_taken", 32'(pred_taken), 32'd0);
    chk("nt2_pc", pred_pc, 32'h104);

    upd(32'h100, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0);
    look(32'h100);
    chk("ctr1_taken", 32'(pred_taken), 32'd0);
    upd(32'h100, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0);
    look(32'h100);
    chk("ctr2_taken", 32'(pred_taken), 32'd1);
    chk("ctr2_pc", pred_pc, 32'h200);

    upd(32'h100, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0);
    upd(32'h100, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0);
    upd(32'h100, 32'h280, 1'b1, 1'b1, 1'b0, 1'b0);
    look(32'h100);
    chk("sat_retarget_pc", pred_pc, 32'h280);
    upd(32'h100, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0);
    look(32'h100);
    chk("sat_nt_taken", 32'(pred_taken), 32'd1);

    upd(32'h300, 32'h304, 1'b0, 1'b1, 1'b0, 1'b0);
    look(32'h300);
    chk("nt_miss_hit", 32'(pred_hit), 32'd0);
    chk("nt_miss_pc", pred_pc, 32'h304);

    look(32'h900);
    chk("alias_hit", 32'(pred_hit), 32'd0);
    chk("alias_pc", pred_pc, 32'h904);

    upd(32'h500, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b0);
    upd(32'h500, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    look(32'h500);
    chk("jal_taken", 32'(pred_taken), 32'd1);
    chk("jal_pc", pred_pc, 32'h1000);

    br_valid = 1'b1;
    br_pc = 32'h600;
    br_target_pc = 32'h700;
    br_taken = 1'b1;
    br_is_branch = 1'b1;
    br_is_return = 1'b0;
    br_is_call = 1'b0;
    fetch_req = 1'b1;
    fetch_pc = 32'h600;
    @(negedge clk);
    br_valid = 1'b0;
    fetch_req = 1'b0;
    chk("rf_old_hit", 32'(pred_hit), 32'd0);
    chk("rf_old_pc", pred_pc, 32'h604);
    look(32'h600);
    chk("rf_new_hit", 32'(pred_hit), 32'd1);
    chk("rf_new_pc", pred_pc, 32'h700);

    upd(32'h400, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b1);
    upd(32'h2010, 32'h3000, 1'b1, 1'b0, 1'b1, 1'b0);
    look(32'h400);
    chk("call_hit", 32'(pred_hit), 32'd1);
    adv();
    look(32'h2010);
`ifdef BRANCH_PREDICTOR_RAS_EN
    chk("ret_ras_pc", pred_pc, 32'h404);
    adv();
    look(32'h2010);
    chk("ret_empty_pc", pred_pc, 32'h3000);
    for (int k = 0; k < 9; k++) begin
      look(32'h400);
      adv();
    end
    chk("ras_cnt_sat", 32'(dut.u_ras.cnt), 32'd8);
    look(32'h2010);
    chk("ret_after9_pc", pred_pc, 32'h404);
`else
    chk("ret_btb_pc", pred_pc, 32'h3000);
    adv();
    look(32'h2010);
    chk("ret_btb_pc2", pred_pc, 32'h3000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL take parameter ENTRIES, default 512, number of BTB entries (power of two, 64..4096).
REQ-002 SHALL take parameter TAG_W, default 9, width of the stored PC tag.
REQ-003 SHALL take parameter RAS_DEPTH, default 8, number of return-stack entries (power of two).
REQ-004 SHALL have ports, one per line (clock and reset first):
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high; clock is clk.
- fetch_req  in  1  lookup request.
- fetch_pc  in  32  PC looked up.
- fetch_advance  in  1  prediction consumed by fetch; commits RAS effects.
- br_valid  in  1  resolved control-transfer result.
- br_pc  in  32  PC of the resolved instruction.
- br_target_pc  in  32  resolved next PC.
- br_taken  in  1  resolved direction.
- br_is_branch  in  1  conditional branch; 0 means jal/jalr.
- br_is_return  in  1  resolved instruction is a return.
- br_is_call  in  1  resolved instruction is a call.
- pred_valid  out  1  prediction valid, one cycle after fetch_req.
- pred_taken  out  1  predicted redirect.
- pred_pc  out  32  predicted next PC.
- pred_hit  out  1  BTB tag match.
- init_done  out  1  table clear finished.

Function
REQ-005 Index SHALL be pc[log2(ENTRIES)+1:2]; tag SHALL be the next TAG_W bits above the index.
REQ-006 An entry SHALL hold a valid bit, tag, target[31:1], a 2-bit saturating counter, is_branch, is_return and is_call.
REQ-007 States SHALL be INIT and READY; INIT SHALL clear one valid bit per cycle, index 0..ENTRIES-1, then move to READY with init_done=1 after exactly ENTRIES cycles.
REQ-008 In INIT, br_valid SHALL be ignored and pred_taken SHALL be 0.
REQ-009 Lookup latency SHALL be 1 cycle: fetch_req at cycle N gives pred_* at N+1; pred_valid=0 at N+1 when no request at N.
REQ-010 pred_hit SHALL equal entry valid AND tag match.
REQ-011 pred_taken SHALL equal pred_hit AND (~is_branch OR counter[1]).
REQ-012 pred_pc SHALL be fetch_pc_r+4 when pred_taken=0; otherwise the RAS top when is_return and RAS non-empty (RAS enabled); otherwise {target,1'b0}.
REQ-013 On br_valid with a matching entry, the counter SHALL increment (saturating at 3) if br_taken, else decrement (saturating at 0); the target, flags and tag SHALL be rewritten.
REQ-014 On br_valid with no match, an entry SHALL be allocated only if br_taken, with counter 2'b10; a not-taken miss SHALL leave the table unchanged.
REQ-015 Update reads SHALL use an independent port; an update and a lookup of the same index in the same cycle SHALL return the pre-update contents (read-first).
REQ-016 Update writes SHALL complete in the cycle br_valid is high; back-to-back br_valid on consecutive cycles SHALL all be applied.

Reset
REQ-017 On rst, outputs SHALL become pred_valid=0, pred_taken=0, pred_hit=0, pred_pc=0 and init_done=0; the FSM SHALL enter INIT at index 0.
REQ-018 rst asserted during INIT SHALL restart the clear at index 0.
REQ-019 RAS pointer and count SHALL reset to 0.

Configuration
REQ-020 Macro BRANCH_PREDICTOR_RAS_EN SHALL compile in the return address stack.
REQ-021 With the macro: on fetch_advance with pred_valid & pred_hit, is_call SHALL push fetch_pc_r+4 and is_return SHALL pop; on overflow the oldest entry is overwritten (count saturates at RAS_DEPTH); a pop with count 0 changes nothing and pred_pc uses the BTB target.
REQ-022 Without the macro: no RAS storage; returns SHALL predict the stored BTB target.

Structure
REQ-023 btb_entry_t, the index/tag width functions and the counter constants (STRONG_NT=0 .. STRONG_T=3) SHALL be in the shared cva5_types package.
REQ-024 The RAS SHALL be a sub-module named return_address_stack; the BTB arrays SHALL be inferred inline as dual-port LUTRAM.

Verification
REQ-025 The bench SHALL check: rst, then ENTRIES=512 -> init_done rises exactly 512 cycles later; lookups before that give pred_taken=0.
REQ-026 The bench SHALL check: br_valid pc=0x100, target=0x200, taken, is_branch -> next fetch 0x100 gives pred_hit=1, pred_taken=1, pred_pc=0x200.
REQ-027 The bench SHALL check: two not-taken updates of pc=0x100 after REQ-026 -> counter 0, pred_taken=0, pred_pc=0x104.
REQ-028 The bench SHALL check: a not-taken update at unseen pc=0x300 -> lookup of 0x300 gives pred_hit=0.
REQ-029 The bench SHALL check, with RAS: call at 0x400 trained and advanced, then return trained and looked up -> pred_pc=0x404; nine calls with RAS_DEPTH=8 -> count stays 8.
REQ-030 The bench SHALL check: update and lookup of the same index in one cycle -> the lookup returns old data and the next lookup returns new data.
